// File: rtl/usb_phy_ls.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : usb_phy_ls
// Purpose  : USB FS/LS PHY front end. Synchronises and glitch-filters raw
//            D+/D- pad samples, decodes line state, detects bus reset and
//            suspend, blanks RX around transmit, and registers the TX drive.
// Options  : define USB_PHY_RESUME_EN to build the resume-K strobe; otherwise
//            resume is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module usb_phy_ls #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 2,
    parameter int LOW_SPEED   = 0,
    parameter int TX_HOLDOFF  = 4,
    parameter int RST_CYCLES  = 120,
    parameter int SUSP_CYCLES = 144000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pad_dp_i,
    input  logic       pad_dn_i,
    output logic       pad_dp_o,
    output logic       pad_dn_o,
    output logic       pad_oe,
    input  logic       tx_dp,
    input  logic       tx_dn,
    input  logic       tx_en,
    output logic       rx_dp,
    output logic       rx_dn,
    output logic       rx_chg,
    output logic [1:0] ls,
    output logic       bus_reset,
    output logic       suspend,
    output logic       resume
);

    localparam int c_FW = $clog2(FILT_LEN + 1);
    localparam int c_RW = $clog2(RST_CYCLES + 1);
    localparam int c_IW = $clog2(SUSP_CYCLES + 1);

    localparam logic [c_FW-1:0] c_FILT_LAST = c_FW'(FILT_LEN - 1);
    localparam logic [c_RW-1:0] c_RST_MAX   = c_RW'(RST_CYCLES);
    localparam logic [c_IW-1:0] c_SUSP_MAX  = c_IW'(SUSP_CYCLES);

    // Idle (J) level per line, bit 1 = D+, bit 0 = D-
    localparam logic [1:0] c_J_LVL = (LOW_SPEED == 0) ? 2'b10 : 2'b01;

    localparam logic [1:0] c_LS_SE0 = 2'b00;
    localparam logic [1:0] c_LS_J   = 2'b01;
    localparam logic [1:0] c_LS_K   = 2'b10;
    localparam logic [1:0] c_LS_SE1 = 2'b11;

    logic [1:0]      w_pad;
    logic [1:0]      w_filt;
    logic [1:0]      w_flip;
    logic            w_blank;
    logic [1:0]      w_ls;
    logic            w_resume;
    logic [c_RW-1:0] w_se0_nxt;
    logic [c_IW-1:0] w_idle_nxt;

    logic            r_rx_chg;
    logic [c_RW-1:0] r_se0_cnt;
    logic [c_IW-1:0] r_idle_cnt;
    logic            r_bus_reset;
    logic            r_suspend;
    logic            r_pad_dp;
    logic            r_pad_dn;
    logic            r_pad_oe;

    assign w_pad = {pad_dp_i, pad_dn_i};

    // RX blanking: tx_en plus a holdoff tail reloaded on every tx_en cycle
    generate
        if (TX_HOLDOFF > 0) begin : g_hold
            localparam int c_HW = $clog2(TX_HOLDOFF + 1);
            localparam logic [c_HW-1:0] c_HOLD_LOAD = c_HW'(TX_HOLDOFF);
            logic [c_HW-1:0] r_hold;

            // Holdoff countdown after tx_en falls
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_hold <= '0;
                end else if (tx_en) begin
                    r_hold <= c_HOLD_LOAD;
                end else if (r_hold != '0) begin
                    r_hold <= r_hold - 1'b1;
                end
            end
            assign w_blank = tx_en | (r_hold != '0);
        end else begin : g_nohold
            assign w_blank = tx_en;
        end
    endgenerate

    // Per-line synchroniser and persistence filter (index 1 = D+, 0 = D-)
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_FW-1:0]        r_cnt;
            logic                   r_filt;
            logic                   w_diff;

            assign w_diff     = (r_sync[SYNC_STAGES-1] != r_filt);
            assign w_flip[gi] = ~w_blank & w_diff & (r_cnt == c_FILT_LAST);
            assign w_filt[gi] = r_filt;

            // Shift in the pad, count disagreeing samples, flip at FILT_LEN
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync <= {SYNC_STAGES{c_J_LVL[gi]}};
                    r_cnt  <= '0;
                    r_filt <= c_J_LVL[gi];
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_pad[gi]};
                    if (w_blank || !w_diff) begin
                        r_cnt <= '0;
                    end else if (w_flip[gi]) begin
                        r_cnt  <= '0;
                        r_filt <= ~r_filt;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Line-state decode; SE1 passes through untouched
    always_comb begin
        w_ls = c_LS_J;
        case (w_filt)
            2'b00:   w_ls = c_LS_SE0;
            2'b11:   w_ls = c_LS_SE1;
            default: w_ls = (w_filt == c_J_LVL) ? c_LS_J : c_LS_K;
        endcase
    end

`ifdef USB_PHY_RESUME_EN
    // Resume strobe: first K cycle while suspended
    assign w_resume = r_suspend & r_rx_chg & (w_ls == c_LS_K);
`else
    assign w_resume = 1'b0;
`endif

    // Saturating SE0 and idle-J counters; both cleared by blanking
    always_comb begin
        w_se0_nxt  = '0;
        w_idle_nxt = '0;
        if (!w_blank && (w_ls == c_LS_SE0)) begin
            w_se0_nxt = (r_se0_cnt == c_RST_MAX) ? r_se0_cnt : r_se0_cnt + 1'b1;
        end
        if (!w_blank && (w_ls == c_LS_J) && !w_resume) begin
            w_idle_nxt = (r_idle_cnt == c_SUSP_MAX) ? r_idle_cnt : r_idle_cnt + 1'b1;
        end
    end

    // Status flags, change pulse and registered TX drive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_chg    <= 1'b0;
            r_se0_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_bus_reset <= 1'b0;
            r_suspend   <= 1'b0;
            r_pad_dp    <= 1'b0;
            r_pad_dn    <= 1'b0;
            r_pad_oe    <= 1'b0;
        end else begin
            r_rx_chg    <= |w_flip;
            r_se0_cnt   <= w_se0_nxt;
            r_idle_cnt  <= w_idle_nxt;
            r_bus_reset <= (w_se0_nxt == c_RST_MAX);
            r_suspend   <= (w_idle_nxt == c_SUSP_MAX);
            r_pad_dp    <= tx_dp;
            r_pad_dn    <= tx_dn;
            r_pad_oe    <= tx_en;
        end
    end

    assign rx_dp     = w_filt[1];
    assign rx_dn     = w_filt[0];
    assign rx_chg    = r_rx_chg;
    assign ls        = w_ls;
    assign bus_reset = r_bus_reset;
    assign suspend   = r_suspend;
    assign resume    = w_resume;
    assign pad_dp_o  = r_pad_dp;
    assign pad_dn_o  = r_pad_dn;
    assign pad_oe    = r_pad_oe;

endmodule
`default_nettype wire

// File: tb/tb_usb_phy_ls.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_usb_phy_ls
// Purpose  : Self-checking bench for usb_phy_ls (FS instance fully exercised,
//            LS instance checked for its reset polarity). SUSP_CYCLES = 200.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_phy_ls;

    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] LJ  = 2'b01;
    localparam logic [1:0] LK  = 2'b10;
`ifdef USB_PHY_RESUME_EN
    localparam logic EXP_RES = 1'b1;
`else
    localparam logic EXP_RES = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, pad_dp_i, pad_dn_i, tx_dp, tx_dn, tx_en;
    logic       pad_dp_o, pad_dn_o, pad_oe, rx_dp, rx_dn, rx_chg;
    logic       bus_reset, suspend, resume;
    logic [1:0] ls;
    logic       l_pad_dp_o, l_pad_dn_o, l_pad_oe, l_rx_dp, l_rx_dn, l_rx_chg;
    logic       l_bus_reset, l_suspend, l_resume;
    logic [1:0] l_ls;

    usb_phy_ls #(.SUSP_CYCLES(200)) u_fs (
        .clk(clk), .rst_n(rst_n), .pad_dp_i(pad_dp_i), .pad_dn_i(pad_dn_i),
        .pad_dp_o(pad_dp_o), .pad_dn_o(pad_dn_o), .pad_oe(pad_oe),
        .tx_dp(tx_dp), .tx_dn(tx_dn), .tx_en(tx_en),
        .rx_dp(rx_dp), .rx_dn(rx_dn), .rx_chg(rx_chg), .ls(ls),
        .bus_reset(bus_reset), .suspend(suspend), .resume(resume)
    );

    usb_phy_ls #(.LOW_SPEED(1), .SUSP_CYCLES(200)) u_ls (
        .clk(clk), .rst_n(rst_n), .pad_dp_i(pad_dp_i), .pad_dn_i(pad_dn_i),
        .pad_dp_o(l_pad_dp_o), .pad_dn_o(l_pad_dn_o), .pad_oe(l_pad_oe),
        .tx_dp(tx_dp), .tx_dn(tx_dn), .tx_en(tx_en),
        .rx_dp(l_rx_dp), .rx_dn(l_rx_dn), .rx_chg(l_rx_chg), .ls(l_ls),
        .bus_reset(l_bus_reset), .suspend(l_suspend), .resume(l_resume)
    );

    typedef struct {
        logic       dp;
        logic       dn;
        logic [1:0] exp_rx;
        logic       exp_chg;
        logic [1:0] exp_ls;
    } vec_t;

    vec_t vq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic dp, input logic dn, input logic [1:0] rx,
                       input logic chg, input logic [1:0] l);
        vec_t v;
        v.dp = dp; v.dn = dn; v.exp_rx = rx; v.exp_chg = chg; v.exp_ls = l;
        vq.push_back(v);
    endtask

    task automatic set_pads(input logic dp, input logic dn);
        pad_dp_i = dp;
        pad_dn_i = dn;
    endtask

    // Wait (bounded) until the FS line state reaches target; timeout fails
    task automatic wait_ls(input logic [1:0] target, input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ls !== target && n < max_cyc);
        chk("wait_ls", {30'd0, ls}, {30'd0, target});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Glitch, latency and both-lines-change sequence from idle J
        add(1,0, 2'b10,0,LJ);  add(0,0, 2'b10,0,LJ);  add(1,0, 2'b10,0,LJ);
        add(1,0, 2'b10,0,LJ);  add(1,0, 2'b10,0,LJ);  add(1,0, 2'b10,0,LJ);
        add(0,0, 2'b10,0,LJ);  add(0,0, 2'b10,0,LJ);  add(0,0, 2'b10,0,LJ);
        add(0,0, 2'b00,1,SE0); add(0,0, 2'b00,0,SE0);
        add(1,0, 2'b00,0,SE0); add(1,0, 2'b00,0,SE0); add(1,0, 2'b00,0,SE0);
        add(1,0, 2'b10,1,LJ);  add(1,0, 2'b10,0,LJ);
        add(0,1, 2'b10,0,LJ);  add(0,1, 2'b10,0,LJ);  add(0,1, 2'b10,0,LJ);
        add(0,1, 2'b01,1,LK);  add(0,1, 2'b01,0,LK);
        add(1,0, 2'b01,0,LK);  add(1,0, 2'b01,0,LK);  add(1,0, 2'b01,0,LK);
        add(1,0, 2'b10,1,LJ);  add(1,0, 2'b10,0,LJ);

        rst_n = 1'b0; tx_en = 1'b0; tx_dp = 1'b0; tx_dn = 1'b0;
        set_pads(1, 0);
        repeat (3) @(negedge clk);

        // Reset state, both polarities
        chk("rst_rx_dp", rx_dp, 1);       chk("rst_rx_dn", rx_dn, 0);
        chk("rst_ls", ls, LJ);            chk("rst_chg", rx_chg, 0);
        chk("rst_bus_reset", bus_reset, 0); chk("rst_suspend", suspend, 0);
        chk("rst_resume", resume, 0);     chk("rst_oe", pad_oe, 0);
        chk("rst_pad_dp", pad_dp_o, 0);   chk("rst_pad_dn", pad_dn_o, 0);
        chk("ls_rst_rx_dp", l_rx_dp, 0);  chk("ls_rst_rx_dn", l_rx_dn, 1);
        chk("ls_rst_ls", l_ls, LJ);
        rst_n = 1'b1;

        // Table-driven vectors; TX lines toggle with tx_en low
        for (int i = 0; i < vq.size(); i++) begin
            set_pads(vq[i].dp, vq[i].dn);
            tx_dp = i[0];
            tx_dn = ~i[0];
            @(negedge clk);
            chk($sformatf("vec%0d_rx", i), {rx_dp, rx_dn}, vq[i].exp_rx);
            chk($sformatf("vec%0d_chg", i), rx_chg, vq[i].exp_chg);
            chk($sformatf("vec%0d_ls", i), ls, vq[i].exp_ls);
            chk($sformatf("vec%0d_pad", i), {pad_oe, pad_dp_o, pad_dn_o},
                {1'b0, i[0], ~i[0]});
        end

        // SE0 for 119 filtered cycles: no bus reset
        set_pads(0, 0);
        wait_ls(SE0, 20);
        for (int k = 0; k <= 122; k++) begin
            if (k > 0) @(negedge clk);
            chk("br_short", bus_reset, 0);
            if (k == 118) chk("br_short_ls_se0", ls, SE0);
            if (k == 119) chk("br_short_ls_j", ls, LJ);
            if (k == 115) set_pads(1, 0);
        end

        // SE0 for 130 filtered cycles: bus reset from index 120
        set_pads(0, 0);
        wait_ls(SE0, 20);
        for (int k = 0; k <= 131; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 130) chk($sformatf("br_long_%0d", k), bus_reset, (k >= 120));
            if (k == 126) set_pads(1, 0);
            if (k == 130) begin
                chk("br_exit_ls", ls, LJ);
                chk("br_exit_hold", bus_reset, 1);
            end
            if (k == 131) chk("br_exit_clear", bus_reset, 0);
        end

        // Transmit for 10 cycles with pads toggling: RX frozen
        tx_en = 1'b1; tx_dp = 1'b0; tx_dn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k[0]) set_pads(0, 1); else set_pads(0, 0);
            @(negedge clk);
            chk("tx_oe", pad_oe, 1);
            chk("tx_pads", {pad_dp_o, pad_dn_o}, 2'b01);
            chk("tx_rx_frozen", {rx_dp, rx_dn}, 2'b10);
            chk("tx_chg", rx_chg, 0);
        end
        tx_en = 1'b0;
        set_pads(0, 1);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            chk("txoff_oe", pad_oe, 0);
            if (j <= 5) begin
                chk("holdoff_rx", {rx_dp, rx_dn}, 2'b10);
                chk("holdoff_chg", rx_chg, 0);
            end else begin
                chk("rx_resume_rx", {rx_dp, rx_dn}, 2'b01);
                chk("rx_resume_chg", rx_chg, 1);
            end
        end

        // Suspend after 200 idle cycles, then K
        set_pads(1, 0);
        wait_ls(LJ, 20);
        for (int k = 0; k <= 210; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= 208) chk($sformatf("susp_%0d", k), suspend, (k >= 200));
            if (k <= 208) chk("susp_resume_low", resume, 0);
            if (k == 205) set_pads(0, 1);
            if (k == 209) begin
                chk("k_ls", ls, LK);
                chk("k_suspend_hold", suspend, 1);
                chk("k_resume", resume, EXP_RES);
            end
            if (k == 210) begin
                chk("k_suspend_clear", suspend, 0);
                chk("k_resume_clear", resume, 0);
            end
        end

        // Reset mid-transmit releases the pad on the same edge
        tx_en = 1'b1; tx_dp = 1'b1; tx_dn = 1'b0;
        @(negedge clk);
        chk("pre_rst_oe", pad_oe, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_oe", {pad_oe, pad_dp_o, pad_dn_o}, 3'b000);
        chk("midrst_rx", {rx_dp, rx_dn}, 2'b10);
        chk("midrst_ls", ls, LJ);
        rst_n = 1'b1; tx_en = 1'b0;

        // Reset during SE0: bus reset needs a full count afterwards
        set_pads(0, 0);
        wait_ls(SE0, 20);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            chk("se0_pre_rst", bus_reset, 0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("se0_rst_ls", ls, LJ);
        chk("se0_rst_br", bus_reset, 0);
        rst_n = 1'b1;
        wait_ls(SE0, 20);
        for (int k = 0; k <= 121; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("br_after_rst_%0d", k), bus_reset, (k >= 120));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_phy_ls.md
Name: usb_phy_ls

Overview:
- Parametrised, vendor-neutral successor to the USB FS PHY front end.
- Synchronises and glitch-filters raw D+/D- pad samples to a configurable depth, and decodes the line state (SE0/J/K/SE1) for FS or LS polarity.
- Detects bus reset (long SE0) and suspend (long idle J), blanks the receiver during and after transmit, and registers the TX drive.
- Sits between the IO buffers (instantiated outside) and the USB RX/TX bit-level logic.

Parameters:
SYNC_STAGES, 2, synchroniser flops per line (>=2)
FILT_LEN, 2, consecutive disagreeing synced samples needed to accept a new level (>=1)
LOW_SPEED, 0, 0 = FS (J = D+ high), 1 = LS (J = D- high)
TX_HOLDOFF, 4, cycles RX stays blanked after tx_en falls (>=0)
RST_CYCLES, 120, SE0 cycles to flag bus reset (2.5 us at 48 MHz)
SUSP_CYCLES, 144000, idle-J cycles to flag suspend (3 ms at 48 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pad_dp_i  in  1  raw D+ input from IO buffer
pad_dn_i  in  1  raw D- input from IO buffer
pad_dp_o  out  1  registered D+ drive
pad_dn_o  out  1  registered D- drive
pad_oe  out  1  registered output enable
tx_dp  in  1  D+ to drive
tx_dn  in  1  D- to drive
tx_en  in  1  drive enable
rx_dp  out  1  filtered D+
rx_dn  out  1  filtered D-
rx_chg  out  1  1-cycle pulse on any filtered-level change
ls  out  2  line state: 00 SE0, 01 J, 10 K, 11 SE1
bus_reset  out  1  SE0 held >= RST_CYCLES
suspend  out  1  J held >= SUSP_CYCLES
resume  out  1  resume-K strobe (see Optional Feature)

Behaviour:
- Reset is synchronous on clk when rst_n=0. Reset values:
  - Synchronisers, rx_dp and rx_dn hold the J level: FS dp=1/dn=0, LS dp=0/dn=1; ls=01.
  - rx_chg=0, bus_reset=0, suspend=0, resume=0.
  - pad_oe=0, pad_dp_o=0, pad_dn_o=0.
  - All counters are 0.
- Synchroniser: SYNC_STAGES-deep shift register per line.
- Filter: one counter per line, width clog2(FILT_LEN+1).
  - Synced sample == filtered bit: counter clears.
  - Sample differs: counter increments. On the cycle it reaches FILT_LEN, the filtered bit flips and the counter clears.
  - Pad-to-rx latency is SYNC_STAGES+FILT_LEN cycles. Pulses shorter than FILT_LEN cycles are rejected.
- rx_chg is registered and high in the same cycle the new rx_dp/rx_dn first appear. Both lines changing in the same cycle give a single pulse.
- ls is a combinational decode of {rx_dp, rx_dn} per LOW_SPEED. SE1 is reported as-is, with no correction.
- Blanking: active while tx_en=1 and for TX_HOLDOFF cycles after tx_en falls. A holdoff counter reloads on each tx_en=1 cycle. While blanked:
  - Filtered bits are frozen and filter counters are held at 0.
  - rx_chg=0.
  - SE0 and idle counters clear; bus_reset and suspend deassert.
- SE0 counter: saturates at RST_CYCLES and clears whenever ls != SE0.
  - bus_reset=1 from the cycle the count reaches RST_CYCLES.
  - bus_reset=0 on the cycle after ls leaves SE0.
- Idle counter: width clog2(SUSP_CYCLES+1); saturates; clears whenever ls != J.
  - suspend=1 on reaching SUSP_CYCLES.
  - suspend=0 on the cycle after ls != J, or when blanking starts.
- TX: pad_dp_o/pad_dn_o/pad_oe are registered copies of tx_dp/tx_dn/tx_en, with 1-cycle latency.
- rst_n low mid-transfer: all state returns to reset values on the next edge, and the pad is released the same edge.
- Reset during SE0: the counter restarts from 0 after rst_n rises. No carry-over.

Optional Feature:
Macro USB_PHY_RESUME_EN.
- Defined: resume pulses high for one cycle when suspend=1 and ls transitions to K. That same cycle clears the idle counter, so suspend=0 on the next cycle.
- Not defined: resume is tied 0 and no extra logic is built. suspend still clears on leaving J.

Test Plan:
- Reset with FS defaults -> rx_dp=1, rx_dn=0, ls=01, all flags 0, pad_oe=0. LS=1 -> rx_dp=0, rx_dn=1, ls=01.
- Hold pad_dp_i 1→0 (pad_dn_i=0) -> rx_dp=0 exactly 4 cycles later, with a single rx_chg pulse coincident. A 1-cycle glitch on D+ -> no change, rx_chg=0.
- SE0 for 119 cycles then J -> bus_reset stays 0. SE0 for 130 cycles -> bus_reset=1 from filtered-SE0 cycle 120, and 0 one cycle after J returns.
- tx_en=1 for 10 cycles with pads toggling -> pad_oe follows 1 cycle late, rx frozen, rx_chg=0. RX resumes 4 cycles after tx_en falls.
- Bench with SUSP_CYCLES=200: J for 200 cycles -> suspend=1. Then K -> with USB_PHY_RESUME_EN, resume=1 for 1 cycle and suspend=0 the next cycle; without the macro, resume stays 0 and suspend=0.
- Assert rst_n=0 during a 60-cycle SE0 then release with SE0 held -> bus_reset asserts only after a full RST_CYCLES (counted from when filtered SE0 reappears).
